apb_master: RTL

APB requester that drives the UART register block from a simple command/response interface, used by the bench-side CPU model and the on-chip test sequencer. It accepts one command at a time, runs a full APB SETUP/ACCESS transfer, and waits for PREADY with a bounded timeout. It returns read data and error status on a valid/ready response channel. Commands outside the configured address window are rejected locally, with no bus activity.

---
 rtl/apb_master_pkg.sv | 31 +++
 rtl/apb_master_if.sv | 52 +++++
 rtl/apb_master_wait_timer.sv | 29 ++
 rtl/apb_master.sv | 127 ++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and register map for the APB requester and the UART completer.
// Also holds the address-window check used on command acceptance.
package apb_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic [11:0] ADDR_TX_DATA_REG = 12'h000;
  localparam logic [11:0] ADDR_RX_DATA_REG = 12'h004;
  localparam logic [11:0] ADDR_CFG_REG     = 12'h008;
  localparam logic [11:0] ADDR_CTRL_REG    = 12'h00C;
  localparam logic [11:0] ADDR_STT_REG     = 12'h010;

  // Bit 12 of each biased difference is set when the bound holds.
  function automatic logic addr_legal(
    input logic [11:0] a,
    input logic [11:0] lo,
    input logic [11:0] hi
  );
    logic [12:0] d_lo;
    logic [12:0] d_hi;
    d_lo = {1'b1, a} - {1'b0, lo};
    d_hi = {1'b1, hi} - {1'b0, a};
    return d_lo[12] && d_hi[12] && (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB bus bundle for the APB requester.
// master is the requester view, slave the environment view.
interface apb_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata,
    output rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite,
    output paddr, pwdata, pstrb,
    input  pready, pslverr, prdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata,
    input  rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite,
    input  paddr, pwdata, pstrb,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/apb_master_wait_timer.sv
// Saturating ACCESS-phase wait counter for the APB requester.
// Flags the last permitted wait cycle before a timeout abort.
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] SAT  = W'(LIMIT);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != SAT)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time, SETUP/ACCESS with bounded wait,
// local rejection of out-of-window addresses, valid/ready response.
module apb_master
  import apb_uart_pkg::*;
#(
  parameter logic [11:0] ADDR_MIN       = 12'h000,
  parameter logic [11:0] ADDR_MAX       = 12'h010,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input logic          pclk,
  input logic          preset,
  apb_master_if.master bus
);

  state_t      r_state;
  logic        r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [11:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;
  logic        r_rsp_valid;
  logic        r_rsp_slverr;
  logic        r_rsp_timeout;
  logic [31:0] r_rsp_rdata;

  logic w_legal;
  logic w_clr;
  logic w_inc;
  logic w_expired;

  assign w_legal = addr_legal(bus.cmd_addr, ADDR_MIN, ADDR_MAX);
  assign w_clr   = (r_state == SETUP);
  assign w_inc   = (r_state == ACCESS);

  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (pclk),
    .i_rst    (preset),
    .i_clr    (w_clr),
    .i_inc    (w_inc),
    .o_expired(w_expired)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state       <= IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_slverr  <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_wdata;
            r_pstrb  <= bus.cmd_write ? bus.cmd_strb : 4'h0;
            if (w_legal) begin
              r_state <= SETUP;
              r_psel  <= 1'b1;
            end else begin
              r_state       <= RESP;
              r_rsp_valid   <= 1'b1;
              r_rsp_slverr  <= 1'b1;
              r_rsp_timeout <= 1'b0;
              r_rsp_rdata   <= '0;
            end
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          // Completion is checked first so pready wins on the last cycle.
          if (bus.pready) begin
            r_state       <= RESP;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_slverr  <= bus.pslverr;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= (!r_pwrite && !bus.pslverr)
                           ? bus.prdata : '0;
          end else if (w_expired) begin
            r_state       <= RESP;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == IDLE);
  assign bus.psel        = r_psel;
  assign bus.penable     = r_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.pstrb       = r_pstrb;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_slverr  = r_rsp_slverr;
  assign bus.rsp_timeout = r_rsp_timeout;

endmodule
